// File: rtl/mixer_seq.sv
// Mixer analog power sequencer on the CPU native bus. Steps pd/ota/buff through
// timed power-up and power-down orders so firmware never drives them directly.
module mixer_seq #(
    parameter int                ADDR_W     = 3,
    parameter int                DATA_W     = 32,
    parameter int                DLY_W      = 16,
    parameter logic [DLY_W-1:0]  T_BIAS_RST = 16'd200,
    parameter logic [DLY_W-1:0]  T_OTA_RST  = 16'd100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              pd,
    output logic              ota,
    output logic [1:0]        buff
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_UP_BIAS = 3'd1,
        ST_UP_OTA  = 3'd2,
        ST_ON      = 3'd3,
        ST_DN_BUFF = 3'd4,
        ST_DN_OTA  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3'd0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3'd1);
    localparam logic [ADDR_W-1:0] A_TBIAS  = ADDR_W'(3'd2);
    localparam logic [ADDR_W-1:0] A_TOTA   = ADDR_W'(3'd3);
    localparam logic [ADDR_W-1:0] A_BCFG   = ADDR_W'(3'd4);

    // A programmed delay of zero still costs one cycle in its state.
    function automatic logic [DLY_W-1:0] dly_sat(input logic [DLY_W-1:0] d);
        logic [DLY_W-1:0] r;
        if (d == '0) r = DLY_W'(1'b1);
        else         r = d;
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [DLY_W-1:0]  cnt_r, cnt_s, cnt_dec_s;
    logic              expired_s;
    logic              err_r, err_s;
    logic [DLY_W-1:0]  t_bias_r, t_bias_s, t_ota_r, t_ota_s;
    logic [1:0]        buff_cfg_r, buff_cfg_s;
    logic              ready_r;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              pd_r, pd_s, ota_r, ota_s;
    logic [1:0]        buff_r, buff_s;
    logic              acc_s, wr_s, rd_s, ctrl_wr_s, up_s, down_s, clr_s;
    logic              busy_s, on_s;
    logic              unused_wdata_s;

    // One access per valid; the registered ready blocks a held valid from repeating it.
    assign acc_s     = valid & ~ready_r;
    assign wr_s      = acc_s & wstrb;
    assign rd_s      = acc_s & ~wstrb;
    assign ctrl_wr_s = wr_s & (address == A_CTRL);
    assign down_s    = ctrl_wr_s & wdata[1];
    assign up_s      = ctrl_wr_s & wdata[0] & ~wdata[1];
    assign clr_s     = ctrl_wr_s & wdata[2];

    assign cnt_dec_s = (cnt_r != '0) ? (cnt_r - DLY_W'(1'b1)) : '0;
    assign expired_s = (cnt_r <= DLY_W'(1'b1));
    assign busy_s    = (state_r != ST_OFF) && (state_r != ST_ON);
    assign on_s      = (state_r == ST_ON);

    assign unused_wdata_s = ^wdata[DATA_W-1:DLY_W];

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign pd    = pd_r;
    assign ota   = ota_r;
    assign buff  = buff_r;

    // Next-state and delay counter: DOWN beats counter expiry, delays sampled at load.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_dec_s;
        case (state_r)
            ST_OFF: begin
                if (up_s) begin
                    state_s = ST_UP_BIAS;
                    cnt_s   = dly_sat(t_bias_r);
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_UP_BIAS: begin
                if (down_s) begin
                    state_s = ST_DN_OTA;
                    cnt_s   = dly_sat(t_bias_r);
                end else if (expired_s) begin
                    state_s = ST_UP_OTA;
                    cnt_s   = dly_sat(t_ota_r);
                end else begin
                    state_s = ST_UP_BIAS;
                end
            end
            ST_UP_OTA: begin
                if (down_s) begin
                    state_s = ST_DN_OTA;
                    cnt_s   = dly_sat(t_bias_r);
                end else if (expired_s) begin
                    state_s = ST_ON;
                end else begin
                    state_s = ST_UP_OTA;
                end
            end
            ST_ON: begin
                if (down_s) state_s = ST_DN_BUFF;
                else        state_s = ST_ON;
            end
            ST_DN_BUFF: begin
                state_s = ST_DN_OTA;
                cnt_s   = dly_sat(t_bias_r);
            end
            ST_DN_OTA: begin
                if (expired_s) state_s = ST_OFF;
                else           state_s = ST_DN_OTA;
            end
            default: begin
                state_s = ST_OFF;
                cnt_s   = '0;
            end
        endcase
    end

    // Sticky error: a rejected UP sets it, CTRL bit2 clears it, set wins a tie.
    always_comb begin
        if (up_s && (state_r != ST_OFF)) err_s = 1'b1;
        else if (clr_s)                  err_s = 1'b0;
        else                             err_s = err_r;
    end

    // Configuration register writes.
    always_comb begin
        t_bias_s   = t_bias_r;
        t_ota_s    = t_ota_r;
        buff_cfg_s = buff_cfg_r;
        if (wr_s) begin
            case (address)
                A_TBIAS: t_bias_s   = wdata[DLY_W-1:0];
                A_TOTA:  t_ota_s    = wdata[DLY_W-1:0];
                A_BCFG:  buff_cfg_s = wdata[1:0];
                default: t_bias_s   = t_bias_r;
            endcase
        end else begin
            buff_cfg_s = buff_cfg_r;
        end
    end

    // Read data mux; CTRL and unmapped words read as zero.
    always_comb begin
        rdata_s = '0;
        if (rd_s) begin
            case (address)
                A_STATUS: rdata_s[5:0]       = {err_r, on_s, busy_s, state_r};
                A_TBIAS:  rdata_s[DLY_W-1:0] = t_bias_r;
                A_TOTA:   rdata_s[DLY_W-1:0] = t_ota_r;
                A_BCFG:   rdata_s[1:0]       = buff_cfg_r;
                default:  rdata_s            = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    // Output decode of the next state so the pins are registered yet track the state.
    always_comb begin
        pd_s   = 1'b0;
        ota_s  = 1'b0;
        buff_s = 2'b00;
        case (state_s)
            ST_OFF:     pd_s = 1'b1;
            ST_UP_BIAS: pd_s = 1'b0;
            ST_UP_OTA:  ota_s = 1'b1;
            ST_ON: begin
                ota_s  = 1'b1;
                buff_s = buff_cfg_s;
            end
            ST_DN_BUFF: ota_s = 1'b1;
            ST_DN_OTA:  ota_s = 1'b0;
            default:    pd_s = 1'b1;
        endcase
    end

    // State, counter and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_OFF;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_bias_r   <= T_BIAS_RST;
            t_ota_r    <= T_OTA_RST;
            buff_cfg_r <= 2'b11;
        end else begin
            t_bias_r   <= t_bias_s;
            t_ota_r    <= t_ota_s;
            buff_cfg_r <= buff_cfg_s;
        end
    end

    // Bus response and analog control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r <= 1'b0;
            rdata_r <= '0;
            pd_r    <= 1'b1;
            ota_r   <= 1'b0;
            buff_r  <= 2'b00;
        end else begin
            ready_r <= acc_s;
            rdata_r <= rdata_s;
            pd_r    <= pd_s;
            ota_r   <= ota_s;
            buff_r  <= buff_s;
        end
    end

endmodule

// File: tb/tb_mixer_seq.sv
// Directed bench for mixer_seq: register access, power-up/down timing,
// abort, error flag and asynchronous reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_mixer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic        wstrb = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        pd;
    logic        ota;
    logic [1:0]  buff;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    mixer_seq dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
        .pd(pd), .ota(ota), .buff(buff)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare {pd, ota, buff} now, then advance to the next falling edge.
    task automatic step(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pd, ota, buff}, {28'd0, exp});
        @(negedge clk);
    endtask

    // Access is sampled on the next rising edge; returns mid-cycle after it.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        valid = 1'b1; wstrb = 1'b1; address = a; wdata = d;
        @(posedge clk); #1;
        chk("wr_ready", {31'd0, ready}, 32'd1);
        valid = 1'b0; wstrb = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        valid = 1'b1; wstrb = 1'b0; address = a; wdata = 32'd0;
        @(posedge clk); #1;
        chk("rd_ready", {31'd0, ready}, 32'd1);
        d = rdata;
        valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {28'd0, pd, ota, buff}, 32'h8);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        bus_read(3'd1, rv); chk("rst_status", rv, 32'h00);
        bus_read(3'd2, rv); chk("rst_tbias", rv, 32'd200);
        bus_read(3'd3, rv); chk("rst_tota", rv, 32'd100);
        bus_read(3'd4, rv); chk("rst_bcfg", rv, 32'h3);

        // Power-up with T_BIAS=3, T_OTA=2, BUFF_CFG=01
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'd2);
        bus_write(3'd4, 32'd1);
        bus_write(3'd0, 32'd1);
        step("up_n1", 4'b0000);
        step("up_n2", 4'b0000);
        step("up_n3", 4'b0000);
        step("up_n4", 4'b0100);
        step("up_n5", 4'b0100);
        step("up_n6", 4'b0101);
        bus_read(3'd1, rv); chk("on_status", rv, 32'h13);
        bus_write(3'd4, 32'd2);
        step("buff_live", 4'b0110);

        // Power-down from ON
        bus_write(3'd0, 32'd2);
        step("dn_m1", 4'b0100);
        step("dn_m2", 4'b0000);
        step("dn_m3", 4'b0000);
        step("dn_m4", 4'b0000);
        step("dn_m5", 4'b1000);
        bus_read(3'd1, rv); chk("dn_status", rv, 32'h00);

        // Zero delays behave as one cycle
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd1);
        step("z_up1", 4'b0000);
        step("z_up2", 4'b0100);
        step("z_on", 4'b0110);
        bus_read(3'd1, rv); chk("z_status", rv, 32'h13);
        bus_read(3'd2, rv); chk("z_tbias", rv, 32'd0);
        bus_write(3'd0, 32'd2);
        step("z_dn1", 4'b0100);
        step("z_dn2", 4'b0000);
        step("z_off", 4'b1000);

        // UP during UP_OTA sets ERR, then abort with UP+DOWN
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'd8);
        bus_write(3'd0, 32'd1);
        repeat (2) @(negedge clk);
        bus_write(3'd0, 32'd1);
        step("err_seq", 4'b0100);
        bus_read(3'd1, rv); chk("err_status", rv, 32'h2A);
        bus_write(3'd0, 32'd3);
        step("abort_1", 4'b0000);
        bus_read(3'd1, rv); chk("abort_status", rv, 32'h2D);
        step("abort_off", 4'b1000);
        bus_read(3'd1, rv); chk("err_sticky", rv, 32'h20);
        bus_write(3'd0, 32'd4);
        bus_read(3'd1, rv); chk("err_clear", rv, 32'h00);

        // Ignored commands and unmapped words
        bus_write(3'd0, 32'd2);
        bus_read(3'd1, rv); chk("dn_in_off", rv, 32'h00);
        bus_write(3'd0, 32'd3);
        bus_read(3'd1, rv); chk("updn_in_off", rv, 32'h00);
        step("off_hold", 4'b1000);
        bus_read(3'd0, rv); chk("ctrl_read", rv, 32'h0);
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, rv); chk("unmapped", rv, 32'h0);
        bus_read(3'd4, rv); chk("bcfg_keep", rv, 32'h2);

        // ERR set and clear in one write while ON, then async reset
        bus_write(3'd2, 32'd1);
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'd1);
        step("r_up1", 4'b0000);
        step("r_up2", 4'b0100);
        step("r_on", 4'b0110);
        bus_write(3'd0, 32'd5);
        bus_read(3'd1, rv); chk("set_wins", rv, 32'h33);
        rst = 1'b0;
        #1;
        chk("async_outs", {28'd0, pd, ota, buff}, 32'h8);
        chk("async_ready", {31'd0, ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(3'd1, rv); chk("rr_status", rv, 32'h00);
        bus_read(3'd2, rv); chk("rr_tbias", rv, 32'd200);
        bus_read(3'd3, rv); chk("rr_tota", rv, 32'd100);
        bus_read(3'd4, rv); chk("rr_bcfg", rv, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mixer_seq.md
# mixer_seq

Power sequencer for the receiver mixer's analog controls. It owns the `pd`, `ota` and `buff` lines and drives them through a timed power-up and power-down order, so firmware never toggles them directly. Bias release, OTA settle and buffer enable follow programmable delays. The block sits on the CPU native bus as a peripheral, in place of direct mixer register writes.

## Interface
- `ADDR_W`, 3: CPU address width.
- `DATA_W`, 32: CPU data width.
- `DLY_W`, 16: delay counter width.
- `T_BIAS_RST`, 16'd200: reset value of T_BIAS.
- `T_OTA_RST`, 16'd100: reset value of T_OTA.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `valid`  in  1  CPU access request.
- `address`  in  ADDR_W  register select.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  1  1 = write, 0 = read.
- `rdata`  out  DATA_W  read data, valid with `ready`.
- `ready`  out  1  access acknowledge.
- `pd`  out  1  mixer power-down, active high.
- `ota`  out  1  OTA enable.
- `buff`  out  2  buffer enable/config.

## Operation
Register map (word index on `address`):
- 0 CTRL (W): bit0 = UP, bit1 = DOWN, bit2 = clear ERR. Write-only; reads return 0.
- 1 STATUS (R): [2:0] state code, [3] busy, [4] on, [5] ERR.
- 2 T_BIAS (RW): [DLY_W-1:0].
- 3 T_OTA (RW): [DLY_W-1:0].
- 4 BUFF_CFG (RW): [1:0], reset 2'b11.
- 5-7: writes ignored, reads return 0.

FSM states, with state code and outputs:
- OFF (0): pd=1, ota=0, buff=0.
- UP_BIAS (1): pd=0, ota=0, buff=0.
- UP_OTA (2): pd=0, ota=1, buff=0.
- ON (3): pd=0, ota=1, buff=BUFF_CFG, read live.
- DN_BUFF (4): pd=0, ota=1, buff=0.
- DN_OTA (5): pd=0, ota=0, buff=0.

Transitions:
- OFF + UP goes to UP_BIAS. The counter loads max(T_BIAS,1).
- UP_BIAS: when the counter expires, go to UP_OTA and load max(T_OTA,1).
- UP_OTA: when the counter expires, go to ON.
- ON + DOWN goes to DN_BUFF. After exactly 1 cycle, go to DN_OTA and load max(T_BIAS,1).
- DN_OTA: when the counter expires, go to OFF.
- DOWN in UP_BIAS or UP_OTA aborts the power-up. The FSM goes to DN_OTA and loads max(T_BIAS,1).
- UP while in any state other than OFF is ignored and sets ERR.
- DOWN while in OFF, DN_BUFF or DN_OTA is ignored and does not set ERR.
- UP and DOWN in the same write: DOWN wins and UP is discarded (ERR unaffected).
- busy = 1 in UP_BIAS, UP_OTA, DN_BUFF and DN_OTA. on = 1 in ON only.
- ERR is sticky. It is cleared by CTRL bit2. If a set and a clear happen in the same write, set wins.
- Delay registers are sampled only at counter load. Writing them mid-wait does not change the current wait.
- The counter is a DLY_W-bit down-counter. A delay value of 0 is treated as 1. There is no wrap: the counter stops at expiry.

## Timing
- Reset values:
  - state = OFF, so pd=1, ota=0, buff=0.
  - ready=0, rdata=0, ERR=0.
  - T_BIAS = T_BIAS_RST, T_OTA = T_OTA_RST, BUFF_CFG = 2'b11.
- Reset asserted mid-sequence forces OFF outputs immediately (asynchronous). There is no graceful power-down.
- `ready` is registered. It goes high on the edge where `valid` is sampled, for one cycle per access. `rdata` is registered on the same edge.
- A CTRL write sampled at edge N moves the state on edge N, so new outputs appear in cycle N+1.
- Power-up latency:
  - UP_BIAS lasts T_BIAS cycles.
  - UP_OTA lasts T_OTA cycles.
  - ON is reached T_BIAS+T_OTA edges after edge N.
- Power-down latency from ON: 1 cycle of DN_BUFF plus T_BIAS cycles of DN_OTA, then OFF (pd=1).
- A BUFF_CFG write while ON is visible on `buff` in the cycle after the write edge.
- Outputs are direct registers or state decode, with no combinational path from bus inputs.

## Test plan
- Reset, then read STATUS -> 0x00. pd=1, ota=0, buff=0. Read T_BIAS -> 200.
- T_BIAS=3, T_OTA=2, BUFF_CFG=2'b01, then write CTRL=1 at edge N:
  - pd falls in cycle N+1.
  - ota rises in cycle N+4.
  - buff=01 and on=1 from cycle N+6.
- From ON, write CTRL=2:
  - buff=0 in the next cycle.
  - ota=0 one cycle later.
  - pd=1 after 3 more cycles.
  - Final STATUS=0x00.
- T_BIAS=0, T_OTA=0, then UP -> UP_BIAS and UP_OTA last 1 cycle each, and ON is reached 2 edges after the write.
- During UP_OTA, write CTRL=1 -> ERR=1 and the sequence is unaffected. Then write CTRL=3 -> abort into DN_OTA, ends in OFF with ERR still 1. Then write CTRL=4 -> ERR=0.
- Assert rst=0 while in ON -> pd=1, ota=0, buff=0 immediately. After release, STATUS=0x00 and delay registers are back at their reset values.
